// File: rtl/junction_ctrl.sv
// Two-road traffic junction controller with pedestrian walk phase.
// A single tick-driven timer times every phase; lamps are registered decodes of the next state.
module junction_ctrl #(
   parameter int GREEN_T  = 30,
   parameter int YELLOW_T = 3,
   parameter int ALLRED_T = 2,
   parameter int WALK_T   = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       req_a,
   input  logic       req_b,
   input  logic       ped_req,
   output logic       a_red,
   output logic       a_yellow,
   output logic       a_green,
   output logic       b_red,
   output logic       b_yellow,
   output logic       b_green,
   output logic       walk,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ALLRED = 3'd1,
      A_GRN  = 3'd2,
      A_YEL  = 3'd3,
      B_GRN  = 3'd4,
      B_YEL  = 3'd5,
      WALK   = 3'd6
   } state_t;

   localparam logic [7:0] GREEN_LIM  = 8'(GREEN_T - 1);
   localparam logic [7:0] YELLOW_LIM = 8'(YELLOW_T - 1);
   localparam logic [7:0] ALLRED_LIM = 8'(ALLRED_T - 1);
   localparam logic [7:0] WALK_LIM   = 8'(WALK_T - 1);

   state_t     state, state_nx;
   logic [7:0] timer, timer_nx, limit;
   logic       expired;
   logic       pend_a, pend_b, pend_p, last;
   logic       pend_a_nx, pend_b_nx, pend_p_nx, last_nx;
   logic       enter_a, enter_b, enter_w;
   state_t     other_road, same_road;
   logic       other_pend, same_pend;
   logic [6:0] lamps, lamps_nx;

   // The timer stops at limit, which doubles as the saturation point for green.
   always_comb begin
      limit = 8'd0;
      case (state)
         ALLRED:        limit = ALLRED_LIM;
         A_GRN, B_GRN:  limit = GREEN_LIM;
         A_YEL, B_YEL:  limit = YELLOW_LIM;
         WALK:          limit = WALK_LIM;
         default:       limit = 8'd0;
      endcase
   end

   assign expired    = tick && (timer == limit);
   assign other_road = last ? A_GRN : B_GRN;
   assign same_road  = last ? B_GRN : A_GRN;
   assign other_pend = last ? pend_a : pend_b;
   assign same_pend  = last ? pend_b : pend_a;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:   state_nx = ALLRED;
         ALLRED: begin
            if (expired) begin
               if (pend_p)          state_nx = WALK;
               else if (other_pend) state_nx = other_road;
               else if (same_pend)  state_nx = same_road;
               else                 state_nx = other_road;
            end
         end
         A_GRN:  if (expired && (pend_b || pend_p)) state_nx = A_YEL;
         B_GRN:  if (expired && (pend_a || pend_p)) state_nx = B_YEL;
         A_YEL:  if (expired) state_nx = ALLRED;
         B_YEL:  if (expired) state_nx = ALLRED;
         WALK:   if (expired) state_nx = ALLRED;
         default: state_nx = IDLE;
      endcase
   end

   assign enter_a = (state_nx == A_GRN) && (state != A_GRN);
   assign enter_b = (state_nx == B_GRN) && (state != B_GRN);
   assign enter_w = (state_nx == WALK)  && (state != WALK);

   always_comb begin
      timer_nx = timer;
      if (state_nx != state)
         timer_nx = 8'd0;
      else if (tick && (timer != limit))
         timer_nx = timer + 8'd1;
   end

   // A request arriving on the clearing cycle survives: set wins over clear.
   assign pend_a_nx = req_a   | (pend_a & ~enter_a);
   assign pend_b_nx = req_b   | (pend_b & ~enter_b);
   assign pend_p_nx = ped_req | (pend_p & ~enter_w);

   always_comb begin
      last_nx = last;
      if (enter_a)      last_nx = 1'b0;
      else if (enter_b) last_nx = 1'b1;
   end

   // Lamp order: a_red a_yellow a_green b_red b_yellow b_green walk
   always_comb begin
      lamps_nx = 7'b000_000_0;
      case (state_nx)
         ALLRED:  lamps_nx = 7'b100_100_0;
         WALK:    lamps_nx = 7'b100_100_1;
         A_GRN:   lamps_nx = 7'b001_100_0;
         A_YEL:   lamps_nx = 7'b010_100_0;
         B_GRN:   lamps_nx = 7'b100_001_0;
         B_YEL:   lamps_nx = 7'b100_010_0;
         default: lamps_nx = 7'b000_000_0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         timer  <= 8'd0;
         pend_a <= 1'b0;
         pend_b <= 1'b0;
         pend_p <= 1'b0;
         last   <= 1'b0;
         lamps  <= 7'b0;
      end else begin
         state  <= state_nx;
         timer  <= timer_nx;
         pend_a <= pend_a_nx;
         pend_b <= pend_b_nx;
         pend_p <= pend_p_nx;
         last   <= last_nx;
         lamps  <= lamps_nx;
      end
   end

   assign {a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk} = lamps;
   assign phase = state;

endmodule

// File: tb/tb_junction_ctrl.sv
// Randomised and directed bench for junction_ctrl against a phase/ticks-remaining reference model.
module tb_junction_ctrl;

   localparam int GREEN_T  = 30;
   localparam int YELLOW_T = 3;
   localparam int ALLRED_T = 2;
   localparam int WALK_T   = 10;

   localparam int P_IDLE = 0, P_ALLRED = 1, P_A_GRN = 2, P_A_YEL = 3;
   localparam int P_B_GRN = 4, P_B_YEL = 5, P_WALK = 6;

   logic       clk = 1'b0;
   logic       rst_n, tick, req_a, req_b, ped_req;
   logic       a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk;
   logic [2:0] phase;

   junction_ctrl #(
      .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .WALK_T(WALK_T)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .req_a(req_a), .req_b(req_b),
      .ped_req(ped_req), .a_red(a_red), .a_yellow(a_yellow), .a_green(a_green),
      .b_red(b_red), .b_yellow(b_yellow), .b_green(b_green), .walk(walk),
      .phase(phase)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int         checks   = 0;
   int         failures = 0;
   logic [9:0] exp_q[$];

   // ---------------- reference model ----------------
   int m_ph, m_rem;
   bit m_pa, m_pb, m_pp, m_last;

   function automatic int dur(input int ph);
      case (ph)
         P_ALLRED:        return ALLRED_T;
         P_A_GRN, P_B_GRN: return GREEN_T;
         P_A_YEL, P_B_YEL: return YELLOW_T;
         P_WALK:          return WALK_T;
         default:         return 0;
      endcase
   endfunction

   // {phase, a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk}
   function automatic logic [9:0] expect_vec(input int ph);
      logic [2:0] p;
      logic [6:0] l;
      p = 3'(ph);
      case (ph)
         P_ALLRED: l = 7'b1001000;
         P_WALK:   l = 7'b1001001;
         P_A_GRN:  l = 7'b0011000;
         P_A_YEL:  l = 7'b0101000;
         P_B_GRN:  l = 7'b1000010;
         P_B_YEL:  l = 7'b1000100;
         default:  l = 7'b0000000;
      endcase
      return {p, l};
   endfunction

   function automatic int choose_after_allred();
      int other, same;
      bit other_p, same_p;
      other   = m_last ? P_A_GRN : P_B_GRN;
      same    = m_last ? P_B_GRN : P_A_GRN;
      other_p = m_last ? m_pa : m_pb;
      same_p  = m_last ? m_pb : m_pa;
      if (m_pp)    return P_WALK;
      if (other_p) return other;
      if (same_p)  return same;
      return other;
   endfunction

   task automatic model_reset();
      m_ph = P_IDLE; m_rem = 0;
      m_pa = 0; m_pb = 0; m_pp = 0; m_last = 0;
   endtask

   task automatic model_edge(input bit tk, input bit ra, input bit rb, input bit rp);
      int  nph;
      bit  last_tick;
      nph       = m_ph;
      last_tick = tk && (m_rem == 1);
      case (m_ph)
         P_IDLE:   nph = P_ALLRED;
         P_ALLRED: if (last_tick) nph = choose_after_allred();
         P_A_GRN:  if (last_tick && (m_pb || m_pp)) nph = P_A_YEL;
         P_B_GRN:  if (last_tick && (m_pa || m_pp)) nph = P_B_YEL;
         P_A_YEL, P_B_YEL, P_WALK: if (last_tick) nph = P_ALLRED;
         default:  nph = P_IDLE;
      endcase
      m_pa = ra || (m_pa && !(nph == P_A_GRN && m_ph != P_A_GRN));
      m_pb = rb || (m_pb && !(nph == P_B_GRN && m_ph != P_B_GRN));
      m_pp = rp || (m_pp && !(nph == P_WALK  && m_ph != P_WALK));
      if (nph == P_A_GRN && m_ph != P_A_GRN) m_last = 0;
      if (nph == P_B_GRN && m_ph != P_B_GRN) m_last = 1;
      if (nph != m_ph)          m_rem = dur(nph);
      else if (tk && m_rem > 1) m_rem = m_rem - 1;
      m_ph = nph;
   endtask

   // ---------------- driver ----------------
   task automatic step(input bit tk, input bit ra, input bit rb, input bit rp);
      tick = tk; req_a = ra; req_b = rb; ped_req = rp;
      @(posedge clk);
      model_edge(tk, ra, rb, rp);
      exp_q.push_back(expect_vec(m_ph));
      @(negedge clk);
   endtask

   task automatic goto_phase(input int ph, input string name);
      for (int i = 0; i < 300 && m_ph != ph; i++) step(1, 0, 0, 0);
      checks++;
      if (m_ph != ph) begin
         failures++;
         $display("FAIL reach_%s: model phase %0d required %0d (cycle budget expired)", name, m_ph, ph);
      end
   endtask

   function automatic logic [9:0] dut_vec();
      return {phase, a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk};
   endfunction

   task automatic check_zero(input string name);
      checks++;
      if (dut_vec() !== 10'b0) begin
         failures++;
         $display("FAIL %s: got %b required %b", name, dut_vec(), 10'b0);
      end
   endtask

   // Asserts reset between edges, checks outputs clear with no clock edge, then releases.
   task automatic apply_reset(input string name);
      tick = 0; req_a = 0; req_b = 0; ped_req = 0;
      #2 rst_n = 1'b0;
      #1 check_zero(name);
      exp_q.delete();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_zero({name, "_hold"});
      rst_n = 1'b1;
   endtask

   // ---------------- monitor / scoreboard ----------------
   task automatic mon_loop();
      logic [9:0] e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (dut_vec() !== e) begin
               failures++;
               $display("FAIL outputs t=%0t: got phase/lamps %b required %b", $time, dut_vec(), e);
            end
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b1; tick = 0; req_a = 0; req_b = 0; ped_req = 0;
      model_reset();
      fork
         mon_loop();
      join_none
      @(negedge clk);
      apply_reset("reset_initial");

      // No requests: IDLE, ALLRED, then B green held indefinitely.
      repeat (45) step(1, 0, 0, 0);

      // Road A request after minimum green served.
      step(1, 1, 0, 0);
      goto_phase(P_A_GRN, "a_grn_1");

      // Pedestrian at tick 5 of A green.
      repeat (4) step(1, 0, 0, 0);
      step(1, 0, 0, 1);
      goto_phase(P_WALK, "walk_1");
      goto_phase(P_B_GRN, "b_grn_after_walk");

      // Vehicle and pedestrian both pending: walk first, then road A.
      repeat (35) step(1, 0, 0, 0);
      step(1, 1, 0, 1);
      goto_phase(P_WALK, "walk_2");
      goto_phase(P_A_GRN, "a_grn_after_walk");

      // Asynchronous reset in the middle of A yellow.
      repeat (35) step(1, 0, 0, 0);
      step(1, 0, 1, 0);
      goto_phase(P_A_YEL, "a_yel");
      step(1, 0, 0, 0);
      apply_reset("reset_mid_yellow");

      // Sparse ticks: one every 4th cycle.
      for (int i = 0; i < 400; i++)
         step((i % 4) == 0, i == 200, 0, 0);

      // Randomised traffic with a random tick rate.
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);

      apply_reset("reset_final");
      repeat (5) step(1, 0, 0, 0);

      #3;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
